// File: rtl/ring_pkg.sv
// Shared ring definitions used by the BRAM ring reader and the producer-side ring writer.
package ring_pkg;

    localparam int BRAM_RD_LATENCY = 2;
    localparam int RING_DEPTH      = 512;
    localparam int RING_AWIDTH     = $clog2(RING_DEPTH);

    typedef logic [RING_AWIDTH-1:0] ring_ptr_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/ring_stream_reader_if.sv
// BRAM read port plus output stream of the ring reader, bundled for master/slave hookup.
interface ring_stream_reader_if #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 64
);
    logic [AWIDTH-1:0] bram_rd_addr;
    logic              bram_rd_en;
    logic [DWIDTH-1:0] bram_rd_data;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output bram_rd_addr,
        output bram_rd_en,
        input  bram_rd_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  bram_rd_addr,
        input  bram_rd_en,
        output bram_rd_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/ring_skid_fifo.sv
// Register-based skid FIFO absorbing BRAM read latency; same-cycle push and pop, synchronous clear.
module ring_skid_fifo #(
    parameter int DWIDTH     = 64,
    parameter int SKID_DEPTH = 8,
    localparam int PW        = $clog2(SKID_DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] pop_data,
    output logic [CW-1:0]     count,
    output logic              empty
);

    logic [DWIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DWIDTH-1:0] mem_d [SKID_DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage is never reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !clear) begin
            assert (!(push && !pop && (count_q == CW'(SKID_DEPTH))))
                else $error("ring_skid_fifo overflow");
            assert (!(pop && (count_q == '0)))
                else $error("ring_skid_fifo underflow");
        end
    end

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ring_stream_reader.sv
// Consumer end of a BRAM ring: prefetches entries into a skid FIFO under credit control and
// streams them out on valid/ready, publishing tail back to the producer.
module ring_stream_reader
    import ring_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int AWIDTH     = $clog2(DEPTH),
    parameter int DWIDTH     = 64,
    parameter int SKID_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AWIDTH-1:0]    head_in,
    input  logic                 head_wr_en,
    input  logic                 flush,
    ring_stream_reader_if.master bus,
    output logic [AWIDTH-1:0]    tail,
    output logic [AWIDTH-1:0]    occup
);

    localparam int CW  = $clog2(SKID_DEPTH) + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] CREDIT_MAX = CW1'(SKID_DEPTH);

    typedef logic [AWIDTH-1:0] ptr_t;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("ring_stream_reader: DEPTH must be a power of two");
    end
    if (!is_pow2(SKID_DEPTH) || (SKID_DEPTH < 5)) begin : g_bad_skid
        $error("ring_stream_reader: SKID_DEPTH must be a power of two and >= 5");
    end
    if (BRAM_RD_LATENCY != 2) begin : g_bad_latency
        $error("ring_stream_reader: return tracking is built for a 2-cycle BRAM");
    end

    ptr_t          head_q, head_d;
    ptr_t          tail_q, tail_d;
    ptr_t          fetch_q, fetch_d;
    ptr_t          rd_addr_q, rd_addr_d;
    logic          rd_en_q, rd_en_d;
    logic          ret_vld_p1_q, ret_vld_p1_d;
    logic          ret_vld_p2_q, ret_vld_p2_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [CW-1:0] discard_q, discard_d;

    ptr_t              head_nxt;
    logic              pop, push, drop, ret_now, issue;
    logic [CW:0]       credit_used;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_head;

    always_comb begin
        head_nxt    = head_wr_en ? head_in : head_q;
        pop         = !fifo_empty && bus.out_ready && !flush;
        ret_now     = ret_vld_p2_q;
        // Returns that belong to a flushed window are swallowed instead of pushed.
        drop        = ret_now && (flush || (discard_q != '0));
        push        = ret_now && !drop;
        credit_used = {1'b0, in_flight_q} + {1'b0, fifo_count};
        issue       = !flush && (discard_q == '0) && (fetch_q != head_q) &&
                      (credit_used < CREDIT_MAX);

        head_d    = head_nxt;
        fetch_d   = fetch_q;
        tail_d    = tail_q;
        discard_d = discard_q;
        if (flush) begin
            fetch_d   = head_nxt;
            tail_d    = head_nxt;
            discard_d = in_flight_q - CW'(ret_now);
        end else begin
            if (issue) fetch_d = fetch_q + ptr_t'(1);
            if (pop)   tail_d  = tail_q + ptr_t'(1);
            if (drop)  discard_d = discard_q - CW'(1);
        end

        in_flight_d  = in_flight_q + CW'(issue) - CW'(ret_now);
        rd_en_d      = issue;
        rd_addr_d    = issue ? fetch_q : rd_addr_q;
        ret_vld_p1_d = rd_en_q;
        ret_vld_p2_d = ret_vld_p1_q;
    end

    // Stage boundary: issue -> BRAM address register -> two-cycle return tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            fetch_q      <= '0;
            rd_addr_q    <= '0;
            rd_en_q      <= 1'b0;
            ret_vld_p1_q <= 1'b0;
            ret_vld_p2_q <= 1'b0;
            in_flight_q  <= '0;
            discard_q    <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            fetch_q      <= fetch_d;
            rd_addr_q    <= rd_addr_d;
            rd_en_q      <= rd_en_d;
            ret_vld_p1_q <= ret_vld_p1_d;
            ret_vld_p2_q <= ret_vld_p2_d;
            in_flight_q  <= in_flight_d;
            discard_q    <= discard_d;
        end
    end

    ring_skid_fifo #(
        .DWIDTH    (DWIDTH),
        .SKID_DEPTH(SKID_DEPTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .push     (push),
        .push_data(bus.bram_rd_data),
        .pop      (pop),
        .pop_data (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign bus.bram_rd_en   = rd_en_q;
    assign bus.bram_rd_addr = rd_addr_q;
    assign bus.out_valid    = !fifo_empty;
    assign bus.out_data     = fifo_head;
    assign tail             = tail_q;
    assign occup            = head_q - tail_q;

endmodule

// File: tb/tb_ring_stream_reader.sv
// Directed bench for ring_stream_reader: a 512-entry ring and a 16-entry ring for wrap-around.
module tb_ring_stream_reader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] head_in = '0;
    logic       head_wr_en = 1'b0;
    logic       flush = 1'b0;
    logic [8:0] tail, occup;

    logic [3:0] head_s = '0;
    logic       wr_s = 1'b0;
    logic       flush_s = 1'b0;
    logic [3:0] tail_s, occup_s;

    ring_stream_reader_if #(.AWIDTH(9), .DWIDTH(64)) bif ();
    ring_stream_reader_if #(.AWIDTH(4), .DWIDTH(64)) sif ();

    ring_stream_reader #(.DEPTH(512), .DWIDTH(64), .SKID_DEPTH(8)) u_dut (
        .clk(clk), .rst(rst), .head_in(head_in), .head_wr_en(head_wr_en), .flush(flush),
        .bus(bif), .tail(tail), .occup(occup)
    );

    ring_stream_reader #(.DEPTH(16), .DWIDTH(64), .SKID_DEPTH(8)) u_small (
        .clk(clk), .rst(rst), .head_in(head_s), .head_wr_en(wr_s), .flush(flush_s),
        .bus(sif), .tail(tail_s), .occup(occup_s)
    );

    function automatic logic [63:0] mem_f(input logic [15:0] a);
        return {16'hC0DE, a, a ^ 16'h5A5A, ~a};
    endfunction

    // Two-cycle BRAM models: address captured on the enable cycle, data registered one cycle later.
    logic [8:0] b_s1_a = '0;
    always @(posedge clk) begin
        if (bif.bram_rd_en) b_s1_a <= bif.bram_rd_addr;
        bif.bram_rd_data <= mem_f({7'd0, b_s1_a});
    end

    logic [3:0] s_s1_a = '0;
    always @(posedge clk) begin
        if (sif.bram_rd_en) s_s1_a <= sif.bram_rd_addr;
        sif.bram_rd_data <= mem_f({12'd0, s_s1_a});
    end

    int rd_cnt = 0;
    always @(posedge clk) if (bif.bram_rd_en) rd_cnt <= rd_cnt + 1;

    int         s_cnt = 0;
    logic [3:0] s_log [32];
    always @(posedge clk) begin
        if (sif.bram_rd_en) begin
            s_log[s_cnt[4:0]] <= sif.bram_rd_addr;
            s_cnt <= s_cnt + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n, input int first, input int budget, output int gaps);
        int got = 0;
        int cyc = 0;
        bit started = 0;
        gaps = 0;
        bif.out_ready = 1'b1;
        while (got < n && cyc < budget) begin
            if (bif.out_valid) begin
                chk($sformatf("data@%0d", (first + got) % 512), bif.out_data,
                    mem_f(16'((first + got) % 512)));
                got++;
                started = 1;
            end else if (started) begin
                gaps++;
            end
            tick();
            cyc++;
        end
        chk("drain_count", 64'(got), 64'(n));
    endtask

    int snap, gaps, got, cyc;

    initial begin
        bif.out_ready = 1'b0;
        sif.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(bif.out_valid), 0);
        chk("rst_rden", 64'(bif.bram_rd_en), 0);
        chk("rst_addr", 64'(bif.bram_rd_addr), 0);
        chk("rst_data", bif.out_data, 0);
        chk("rst_tail", 64'(tail), 0);
        chk("rst_occup", 64'(occup), 0);
        rst = 1'b1;
        tick();

        // Single entry latency
        bif.out_ready = 1'b1;
        head_in = 9'd1; head_wr_en = 1'b1;
        tick();
        head_wr_en = 1'b0;
        chk("t1_occup_n1", 64'(occup), 1);
        chk("t1_rden_n1", 64'(bif.bram_rd_en), 0);
        tick();
        chk("t1_rden_n2", 64'(bif.bram_rd_en), 1);
        chk("t1_addr_n2", 64'(bif.bram_rd_addr), 0);
        tick();
        tick();
        chk("t1_valid_n4", 64'(bif.out_valid), 0);
        tick();
        chk("t1_valid_n5", 64'(bif.out_valid), 1);
        chk("t1_data_n5", bif.out_data, mem_f(16'd0));
        chk("t1_tail_n5", 64'(tail), 0);
        tick();
        chk("t1_valid_n6", 64'(bif.out_valid), 0);
        chk("t1_tail_n6", 64'(tail), 1);
        chk("t1_occup_n6", 64'(occup), 0);

        // 100 entries back to back
        snap = rd_cnt;
        head_in = 9'd101; head_wr_en = 1'b1;
        tick();
        head_wr_en = 1'b0;
        drain(100, 1, 300, gaps);
        chk("t2_gaps", 64'(gaps), 0);
        repeat (3) tick();
        chk("t2_tail", 64'(tail), 101);
        chk("t2_occup", 64'(occup), 0);
        chk("t2_reads", 64'(rd_cnt - snap), 100);

        // Backpressure: credit limits prefetch to the skid depth
        bif.out_ready = 1'b0;
        snap = rd_cnt;
        head_in = 9'd121; head_wr_en = 1'b1;
        tick();
        head_wr_en = 1'b0;
        repeat (20) tick();
        chk("t3_reads_held", 64'(rd_cnt - snap), 8);
        chk("t3_rden_held", 64'(bif.bram_rd_en), 0);
        chk("t3_valid_held", 64'(bif.out_valid), 1);
        chk("t3_occup_held", 64'(occup), 20);
        drain(20, 101, 200, gaps);
        repeat (3) tick();
        chk("t3_reads_total", 64'(rd_cnt - snap), 20);
        chk("t3_tail", 64'(tail), 121);

        // Reset while streaming
        head_in = 9'd171; head_wr_en = 1'b1;
        tick();
        head_wr_en = 1'b0;
        repeat (9) tick();
        chk("t6_streaming", 64'(bif.out_valid), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t6_valid", 64'(bif.out_valid), 0);
        chk("t6_rden", 64'(bif.bram_rd_en), 0);
        chk("t6_addr", 64'(bif.bram_rd_addr), 0);
        chk("t6_data", bif.out_data, 0);
        chk("t6_tail", 64'(tail), 0);
        chk("t6_occup", 64'(occup), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t6_quiet%0d", i), {62'd0, bif.out_valid, bif.bram_rd_en}, 0);
        end

        // Flush with 3 returns in flight and 4 entries buffered
        bif.out_ready = 1'b0;
        head_in = 9'd20; head_wr_en = 1'b1;
        tick();
        head_wr_en = 1'b0;
        repeat (7) tick();
        chk("t5_pre_valid", 64'(bif.out_valid), 1);
        chk("t5_pre_rden", 64'(bif.bram_rd_en), 1);
        chk("t5_pre_addr", 64'(bif.bram_rd_addr), 6);
        flush = 1'b1; head_in = 9'd40; head_wr_en = 1'b1;
        tick();
        flush = 1'b0; head_wr_en = 1'b0;
        chk("t5_valid_after", 64'(bif.out_valid), 0);
        chk("t5_tail", 64'(tail), 40);
        chk("t5_occup", 64'(occup), 0);
        head_in = 9'd45; head_wr_en = 1'b1;
        tick();
        head_wr_en = 1'b0;
        chk("t5_hold1", {62'd0, bif.out_valid, bif.bram_rd_en}, 0);
        tick();
        chk("t5_hold2", {62'd0, bif.out_valid, bif.bram_rd_en}, 0);
        tick();
        chk("t5_first_rden", 64'(bif.bram_rd_en), 1);
        chk("t5_first_addr", 64'(bif.bram_rd_addr), 40);
        drain(5, 40, 50, gaps);
        tick();
        chk("t5_tail_end", 64'(tail), 45);

        // Wrap-around on the 16-entry ring
        sif.out_ready = 1'b1;
        head_s = 4'd14; wr_s = 1'b1;
        tick();
        wr_s = 1'b0;
        repeat (30) tick();
        chk("t4_tail_pre", 64'(tail_s), 14);
        chk("t4_occup_pre", 64'(occup_s), 0);
        snap = s_cnt;
        head_s = 4'd3; wr_s = 1'b1;
        tick();
        wr_s = 1'b0;
        chk("t4_occup_wrap", 64'(occup_s), 5);
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 40) begin
            if (sif.out_valid) begin
                chk($sformatf("t4_data%0d", got), sif.out_data, mem_f(16'((14 + got) % 16)));
                got++;
            end
            tick();
            cyc++;
        end
        chk("t4_count", 64'(got), 5);
        tick();
        chk("t4_tail", 64'(tail_s), 3);
        chk("t4_occup", 64'(occup_s), 0);
        chk("t4_reads", 64'(s_cnt - snap), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_addr%0d", i), 64'(s_log[5'(snap + i)]), 64'((14 + i) % 16));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
